// File: rtl/pipe_pkg.sv
// Shared defaults and the stage record for the pipeline register chain.
package pipe_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_DEPTH = 3;
  localparam int DEF_CNT_W = 16;

  typedef struct packed {
    logic                 valid;
    logic [DEF_WIDTH-1:0] data;
  } stage_t;
endpackage

// File: rtl/pipe_stage.sv
// One valid/data pipeline register: load-enable takes the upstream entry,
// kill drops the valid bit while the data is held.
module pipe_stage import pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             kill,
  input  logic             inValid,
  input  logic [WIDTH-1:0] inData,
  output logic             valid,
  output logic [WIDTH-1:0] data
);
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (en) begin
      valid <= inValid;
      data  <= inData;
    end else if (kill) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/pipe_reg_chain.sv
// DEPTH-stage register chain with hold, bubble and per-stage flush.
// Performance counters are built only when PIPE_REG_CHAIN_PERF_EN is defined.
module pipe_reg_chain import pipe_pkg::*; #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [WIDTH-1:0]       in_data,
  input  logic                   hold,
  input  logic                   bubble,
  input  logic [DEPTH-1:0]       flush_mask,
  output logic                   in_ready,
  output logic [DEPTH-1:0]       stage_valid,
  output logic [DEPTH*WIDTH-1:0] stage_data,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic [CNT_W-1:0]       flush_count
);
  logic [DEPTH-1:0]            vEff;
  logic [DEPTH-1:0][WIDTH-1:0] dataQ;

  assign vEff       = stage_valid & ~flush_mask;
  assign in_ready   = ~hold & ~bubble;
  assign stage_data = dataQ;
  assign out_valid  = vEff[DEPTH-1];
  assign out_data   = dataQ[DEPTH-1];

  for (genvar i = 0; i < DEPTH; i++) begin : gStage
    logic             en, kill, srcValid;
    logic [WIDTH-1:0] srcData;
    if (i == 0) begin : gHead
      // A bubble leaves stage 0 data in place and only drops its valid.
      assign en       = ~hold & ~bubble;
      assign kill     = hold ? flush_mask[0] : bubble;
      assign srcValid = in_valid;
      assign srcData  = in_data;
    end else begin : gBody
      assign en       = ~hold;
      assign kill     = flush_mask[i];
      assign srcValid = vEff[i-1];
      assign srcData  = dataQ[i-1];
    end
    pipe_stage #(.WIDTH(WIDTH)) uStage (
      .clk(clk), .rst(rst), .en(en), .kill(kill),
      .inValid(srcValid), .inData(srcData),
      .valid(stage_valid[i]), .data(dataQ[i])
    );
  end

`ifdef PIPE_REG_CHAIN_PERF_EN
  localparam int SW = CNT_W + 9;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic [CNT_W-1:0] stallQ, flushQ;
  logic [SW-1:0]    killCnt, flushSum;

  always_comb begin
    killCnt = '0;
    for (int i = 0; i < DEPTH; i++)
      killCnt = killCnt + SW'(stage_valid[i] & flush_mask[i]);
    flushSum = SW'(flushQ) + killCnt;
  end

  // Both counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallQ <= '0;
      flushQ <= '0;
    end else begin
      if (hold && stallQ != CNT_MAX) stallQ <= stallQ + CNT_W'(1);
      flushQ <= (flushSum > SW'(CNT_MAX)) ? CNT_MAX : flushSum[CNT_W-1:0];
    end
  end

  assign stall_cycles = stallQ;
  assign flush_count  = flushQ;
`else
  assign stall_cycles = '0;
  assign flush_count  = '0;
`endif
endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed table-driven bench for pipe_reg_chain (DEPTH=3) plus a DEPTH=1,
// CNT_W=2 instance for the single-stage and counter saturation cases.
module tb_pipe_reg_chain;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int nTests = 0;
  int nFail  = 0;

  // main DUT
  logic        rst, inValid, hold, bubble, inReady, outValid;
  logic [15:0] inData, outData;
  logic [2:0]  flushMask, stageValid;
  logic [47:0] stageData;
  logic [15:0] stallCycles, flushCount;

  pipe_reg_chain #(.WIDTH(16), .DEPTH(3), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(inValid), .in_data(inData), .hold(hold),
    .bubble(bubble), .flush_mask(flushMask), .in_ready(inReady),
    .stage_valid(stageValid), .stage_data(stageData), .out_valid(outValid),
    .out_data(outData), .stall_cycles(stallCycles), .flush_count(flushCount)
  );

  // single-stage DUT with tiny counters
  logic        rst1, inValid1, hold1, bubble1, inReady1, outValid1;
  logic [15:0] inData1, outData1, stageData1;
  logic [0:0]  flushMask1, stageValid1;
  logic [1:0]  stall1, flush1;

  pipe_reg_chain #(.WIDTH(16), .DEPTH(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst(rst1), .in_valid(inValid1), .in_data(inData1), .hold(hold1),
    .bubble(bubble1), .flush_mask(flushMask1), .in_ready(inReady1),
    .stage_valid(stageValid1), .stage_data(stageData1), .out_valid(outValid1),
    .out_data(outData1), .stall_cycles(stall1), .flush_count(flush1)
  );

  typedef struct {
    logic        rst, inV;
    logic [15:0] inD;
    logic        hold, bubble;
    logic [2:0]  mask;
    logic        rdy, chkOv, ov;
    logic [2:0]  sv;
    logic [15:0] d0, d1, d2;
    int          stall, flush;
  } vec_t;

  vec_t tv[22];

  function automatic vec_t mk(logic r, logic v, logic [15:0] d, logic h, logic b,
                              logic [2:0] m, logic rdy, logic chkOv, logic ov,
                              logic [2:0] sv, logic [15:0] d0, logic [15:0] d1,
                              logic [15:0] d2, int st, int fl);
    vec_t t;
    t.rst = r; t.inV = v; t.inD = d; t.hold = h; t.bubble = b; t.mask = m;
    t.rdy = rdy; t.chkOv = chkOv; t.ov = ov; t.sv = sv;
    t.d0 = d0; t.d1 = d1; t.d2 = d2;
`ifdef PIPE_REG_CHAIN_PERF_EN
    t.stall = st; t.flush = fl;
`else
    t.stall = 0; t.flush = 0;
`endif
    return t;
  endfunction

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    //            rst v  data    h  b  mask   rdy chk ov  sv      d0      d1      d2   st fl
    tv[0]  = mk(1, 0, 16'h0,    0, 0, 3'b000, 1, 0, 0, 3'b000, 16'h0,    16'h0,    16'h0,    0, 0);
    tv[1]  = mk(0, 1, 16'h1111, 0, 0, 3'b000, 1, 1, 0, 3'b001, 16'h1111, 16'h0,    16'h0,    0, 0);
    tv[2]  = mk(0, 1, 16'h2222, 0, 0, 3'b000, 1, 1, 0, 3'b011, 16'h2222, 16'h1111, 16'h0,    0, 0);
    tv[3]  = mk(0, 1, 16'h3333, 0, 0, 3'b000, 1, 1, 0, 3'b111, 16'h3333, 16'h2222, 16'h1111, 0, 0);
    tv[4]  = mk(0, 0, 16'h0,    0, 0, 3'b000, 1, 1, 1, 3'b110, 16'h0,    16'h3333, 16'h2222, 0, 0);
    tv[5]  = mk(0, 0, 16'h0,    0, 0, 3'b000, 1, 1, 1, 3'b100, 16'h0,    16'h0,    16'h3333, 0, 0);
    tv[6]  = mk(0, 0, 16'h0,    0, 0, 3'b000, 1, 1, 1, 3'b000, 16'h0,    16'h0,    16'h0,    0, 0);
    tv[7]  = mk(0, 1, 16'h000A, 0, 0, 3'b000, 1, 1, 0, 3'b001, 16'h000A, 16'h0,    16'h0,    0, 0);
    tv[8]  = mk(0, 1, 16'h000B, 0, 0, 3'b000, 1, 1, 0, 3'b011, 16'h000B, 16'h000A, 16'h0,    0, 0);
    tv[9]  = mk(0, 1, 16'h000C, 0, 0, 3'b000, 1, 1, 0, 3'b111, 16'h000C, 16'h000B, 16'h000A, 0, 0);
    tv[10] = mk(0, 1, 16'hDEAD, 1, 0, 3'b000, 0, 1, 1, 3'b111, 16'h000C, 16'h000B, 16'h000A, 1, 0);
    tv[11] = mk(0, 1, 16'hDEAD, 1, 0, 3'b000, 0, 1, 1, 3'b111, 16'h000C, 16'h000B, 16'h000A, 2, 0);
    tv[12] = mk(0, 1, 16'hDEAD, 1, 0, 3'b000, 0, 1, 1, 3'b111, 16'h000C, 16'h000B, 16'h000A, 3, 0);
    tv[13] = mk(0, 1, 16'hDEAD, 1, 0, 3'b000, 0, 1, 1, 3'b111, 16'h000C, 16'h000B, 16'h000A, 4, 0);
    tv[14] = mk(0, 1, 16'h4444, 0, 0, 3'b011, 1, 1, 1, 3'b001, 16'h4444, 16'h0,    16'h0,    4, 2);
    tv[15] = mk(0, 1, 16'h5555, 0, 0, 3'b000, 1, 1, 0, 3'b011, 16'h5555, 16'h4444, 16'h0,    4, 2);
    tv[16] = mk(0, 1, 16'h6666, 0, 0, 3'b000, 1, 1, 0, 3'b111, 16'h6666, 16'h5555, 16'h4444, 4, 2);
    tv[17] = mk(0, 1, 16'h7777, 1, 0, 3'b100, 0, 1, 0, 3'b011, 16'h6666, 16'h5555, 16'h0,    5, 3);
    tv[18] = mk(0, 1, 16'hBEEF, 0, 1, 3'b000, 0, 1, 0, 3'b110, 16'h0,    16'h6666, 16'h5555, 5, 3);
    tv[19] = mk(0, 1, 16'hBEEF, 0, 0, 3'b000, 1, 1, 1, 3'b101, 16'hBEEF, 16'h0,    16'h6666, 5, 3);
    tv[20] = mk(0, 1, 16'h1234, 1, 1, 3'b000, 0, 1, 1, 3'b101, 16'hBEEF, 16'h0,    16'h6666, 6, 3);
    tv[21] = mk(1, 1, 16'h5678, 1, 0, 3'b111, 0, 1, 0, 3'b000, 16'h0,    16'h0,    16'h0,    0, 0);

    rst = 1'b1; inValid = 1'b0; inData = '0; hold = 1'b0; bubble = 1'b0; flushMask = '0;
    rst1 = 1'b1; inValid1 = 1'b0; inData1 = '0; hold1 = 1'b0; bubble1 = 1'b0; flushMask1 = '0;

    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      rst = tv[i].rst; inValid = tv[i].inV; inData = tv[i].inD;
      hold = tv[i].hold; bubble = tv[i].bubble; flushMask = tv[i].mask;
      #1;
      chk($sformatf("v%0d in_ready", i), 48'(inReady), 48'(tv[i].rdy));
      if (tv[i].chkOv) chk($sformatf("v%0d out_valid", i), 48'(outValid), 48'(tv[i].ov));
      @(posedge clk); #1;
      chk($sformatf("v%0d stage_valid", i), 48'(stageValid), 48'(tv[i].sv));
      if (tv[i].rst) begin
        chk($sformatf("v%0d stage_data", i), stageData, 48'h0);
        chk($sformatf("v%0d out_data", i), 48'(outData), 48'h0);
      end else begin
        if (tv[i].sv[0]) chk($sformatf("v%0d d0", i), 48'(stageData[15:0]),  48'(tv[i].d0));
        if (tv[i].sv[1]) chk($sformatf("v%0d d1", i), 48'(stageData[31:16]), 48'(tv[i].d1));
        if (tv[i].sv[2]) chk($sformatf("v%0d d2", i), 48'(stageData[47:32]), 48'(tv[i].d2));
        if (tv[i].sv[2]) chk($sformatf("v%0d out_data", i), 48'(outData), 48'(tv[i].d2));
      end
      chk($sformatf("v%0d stall_cycles", i), 48'(stallCycles), 48'(tv[i].stall));
      chk($sformatf("v%0d flush_count", i), 48'(flushCount), 48'(tv[i].flush));
    end

    // out_valid after the reset edge, with reset released and no flush
    @(negedge clk);
    rst = 1'b0; hold = 1'b0; flushMask = '0; inValid = 1'b0;
    #1 chk("post-reset out_valid", 48'(outValid), 48'h0);

    // single-stage instance: latency of one edge, then hold saturation
    @(negedge clk);
    rst1 = 1'b0; inValid1 = 1'b1; inData1 = 16'hA5A5;
    @(posedge clk); #1;
    chk("d1 out_valid", 48'(outValid1), 48'h1);
    chk("d1 out_data", 48'(outData1), 48'hA5A5);
    @(negedge clk);
    hold1 = 1'b1; inData1 = 16'h0F0F;
    #1 chk("d1 in_ready hold", 48'(inReady1), 48'h0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
`ifdef PIPE_REG_CHAIN_PERF_EN
      chk($sformatf("d1 stall %0d", k), 48'(stall1), 48'(k > 3 ? 3 : k));
`else
      chk($sformatf("d1 stall %0d", k), 48'(stall1), 48'h0);
`endif
      chk($sformatf("d1 held data %0d", k), 48'(outData1), 48'hA5A5);
    end
    @(negedge clk);
    hold1 = 1'b0; inValid1 = 1'b0; flushMask1 = 1'b1;
    #1 chk("d1 flushed out_valid", 48'(outValid1), 48'h0);
    @(posedge clk); #1;
`ifdef PIPE_REG_CHAIN_PERF_EN
    chk("d1 flush_count", 48'(flush1), 48'h1);
`else
    chk("d1 flush_count", 48'(flush1), 48'h0);
`endif
    chk("d1 stage_valid", 48'(stageValid1), 48'h0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
